// File: rtl/phase_seq_ctrl.sv
// Phase sequencer controller: steps a downstream IDLE->S1->S2->IDLE FSM through
// repeated S1/S2 dwell runs, with abort handling and one-shot en pulses.
module phase_seq_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] dwell_s1,
  input  logic [CNT_W-1:0] dwell_s2,
  input  logic [3:0]       rep,
  output logic             en,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {StIdle, StS1, StS2, StWrap} state_e;

  localparam logic [1:0] PhIdle = 2'b00;
  localparam logic [1:0] PhS1   = 2'b01;
  localparam logic [1:0] PhS2   = 2'b10;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cfg_s1_q;
  logic [CNT_W-1:0] cfg_s2_q;
  logic [3:0]       runs_q;
  logic             abort_pend_q;

  logic [CNT_W-1:0] s1_last_cnt;
  logic [CNT_W-1:0] s2_last_cnt;
  logic             s1_last;
  logic             s2_last;

  // Final count value of each phase; a dwell of 0 behaves as a dwell of 1.
  always_comb begin
    s1_last_cnt = (cfg_s1_q == '0) ? '0 : cfg_s1_q - CNT_W'(1);
    s2_last_cnt = (cfg_s2_q == '0) ? '0 : cfg_s2_q - CNT_W'(1);
    s1_last     = (cnt_q == s1_last_cnt);
    s2_last     = (cnt_q == s2_last_cnt);
  end

  assign busy = (state_q != StIdle);

  // Controller FSM with registered en/phase/done/aborted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cfg_s1_q     <= '0;
      cfg_s2_q     <= '0;
      runs_q       <= '0;
      abort_pend_q <= 1'b0;
      en           <= 1'b0;
      phase        <= PhIdle;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      en      <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // abort is not looked at here, so start always wins.
          if (start) begin
            cfg_s1_q <= dwell_s1;
            cfg_s2_q <= dwell_s2;
            runs_q   <= rep;
            cnt_q    <= '0;
            state_q  <= StS1;
            en       <= 1'b1;
            phase    <= PhS1;
          end
        end
        StS1: begin
          if (abort || s1_last) begin
            cnt_q   <= '0;
            state_q <= StS2;
            en      <= 1'b1;
            phase   <= PhS2;
            if (abort) begin
              // Downstream must still pass through S2 before reaching IDLE.
              abort_pend_q <= 1'b1;
              runs_q       <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StS2: begin
          if (abort_pend_q || abort) begin
            cnt_q        <= '0;
            runs_q       <= '0;
            abort_pend_q <= 1'b0;
            state_q      <= StIdle;
            en           <= 1'b1;
            phase        <= PhIdle;
            aborted      <= 1'b1;
          end else if (s2_last) begin
            cnt_q <= '0;
            en    <= 1'b1;
            phase <= PhIdle;
            if (runs_q != '0) begin
              runs_q  <= runs_q - 4'd1;
              state_q <= StWrap;
            end else begin
              state_q <= StIdle;
              done    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StWrap: begin
          if (abort) begin
            // Downstream already stepped back to IDLE on entry to WRAP: no pulse.
            runs_q       <= '0;
            abort_pend_q <= 1'b0;
            state_q      <= StIdle;
            aborted      <= 1'b1;
          end else begin
            cnt_q   <= '0;
            state_q <= StS1;
            en      <= 1'b1;
            phase   <= PhS1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Directed self-checking bench for phase_seq_ctrl.
module tb_phase_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] dwell_s1;
  logic [7:0] dwell_s2;
  logic [3:0] rep;
  logic       en;
  logic [1:0] phase;
  logic       busy;
  logic       done;
  logic       aborted;

  int total;
  int bad;

  phase_seq_ctrl #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .dwell_s1 (dwell_s1),
    .dwell_s2 (dwell_s2),
    .rep      (rep),
    .en       (en),
    .phase    (phase),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream stepping FSM driven by en, plus last cycle's commanded phase.
  logic [1:0] model_q;
  logic [1:0] prev_phase_q;
  logic       mon_on;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q      <= 2'b00;
      prev_phase_q <= 2'b00;
    end else begin
      prev_phase_q <= phase;
      if (en) model_q <= (model_q == 2'b00) ? 2'b01 : (model_q == 2'b01) ? 2'b10 : 2'b00;
    end
  end

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      total++;
      if (model_q !== prev_phase_q) begin
        bad++;
        $display("FAIL downstream_model t=%0t: got %b want %b", $time, model_q, prev_phase_q);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if ({en, phase, busy, done, aborted} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 000000", {en, phase, busy, done, aborted});
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    total++;
    if ({en, phase, busy, done, aborted} !== 6'b0) begin
      bad++;
      $display("FAIL reset_release_idle: got %b want 000000", {en, phase, busy, done, aborted});
    end
  endtask

  task automatic test_basic();
    logic [1:0] ph [1:7];
    logic [7:1] en_e, dn_e, bz_e;
    ph   = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
    en_e = 7'b0101001;  // cycles 1, 4, 6
    dn_e = 7'b0100000;  // cycle 6
    bz_e = 7'b0011111;  // cycles 1-5
    dwell_s1 = 8'd3; dwell_s2 = 8'd2; rep = 4'd0;
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      start = 1'b0;
      total++;
      if (phase !== ph[c] || en !== en_e[c] || done !== dn_e[c] || busy !== bz_e[c] ||
          aborted !== 1'b0) begin
        bad++;
        $display("FAIL basic c%0d: got ph=%b en=%b dn=%b bz=%b ab=%b want ph=%b en=%b dn=%b bz=%b ab=0",
                 c, phase, en, done, busy, aborted, ph[c], en_e[c], dn_e[c], bz_e[c]);
      end
    end
  endtask

  task automatic test_rep();
    logic [1:0] ph [1:13];
    logic [13:1] en_e, dn_e, bz_e;
    int pulses;
    ph   = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
             2'b00, 2'b00};
    en_e = 13'b0101001101001;  // cycles 1, 4, 6, 7, 10, 12
    dn_e = 13'b0100000000000;  // cycle 12
    bz_e = 13'b0011111111111;  // cycles 1-11
    pulses = 0;
    dwell_s1 = 8'd3; dwell_s2 = 8'd2; rep = 4'd1;
    start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      start = 1'b0;
      // Changing the inputs mid-run must not affect the captured configuration.
      dwell_s1 = 8'd9; dwell_s2 = 8'd9; rep = 4'd5;
      if (en) pulses++;
      total++;
      if (phase !== ph[c] || en !== en_e[c] || done !== dn_e[c] || busy !== bz_e[c] ||
          aborted !== 1'b0) begin
        bad++;
        $display("FAIL rep c%0d: got ph=%b en=%b dn=%b bz=%b ab=%b want ph=%b en=%b dn=%b bz=%b ab=0",
                 c, phase, en, done, busy, aborted, ph[c], en_e[c], dn_e[c], bz_e[c]);
      end
    end
    total++;
    if (pulses != 6) begin
      bad++;
      $display("FAIL rep_pulse_count: got %0d want 6", pulses);
    end
  endtask

  task automatic test_zero_dwell();
    logic [1:0] ph [1:4];
    logic [4:1] en_e, dn_e, bz_e;
    ph   = '{2'b01, 2'b10, 2'b00, 2'b00};
    en_e = 4'b0111;
    dn_e = 4'b0100;
    bz_e = 4'b0011;
    dwell_s1 = 8'd0; dwell_s2 = 8'd0; rep = 4'd0;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      start = 1'b0;
      total++;
      if (phase !== ph[c] || en !== en_e[c] || done !== dn_e[c] || busy !== bz_e[c]) begin
        bad++;
        $display("FAIL zero_dwell c%0d: got ph=%b en=%b dn=%b bz=%b want ph=%b en=%b dn=%b bz=%b",
                 c, phase, en, done, busy, ph[c], en_e[c], dn_e[c], bz_e[c]);
      end
    end
  endtask

  task automatic test_abort_s1();
    logic [1:0] ph [1:6];
    logic [6:1] en_e, ab_e;
    ph   = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    en_e = 6'b001101;
    ab_e = 6'b001000;
    dwell_s1 = 8'd10; dwell_s2 = 8'd5; rep = 4'd2;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      start = 1'b0;
      abort = (c == 2);
      total++;
      if (phase !== ph[c] || en !== en_e[c] || aborted !== ab_e[c] || done !== 1'b0) begin
        bad++;
        $display("FAIL abort_s1 c%0d: got ph=%b en=%b ab=%b dn=%b want ph=%b en=%b ab=%b dn=0",
                 c, phase, en, aborted, done, ph[c], en_e[c], ab_e[c]);
      end
    end
  endtask

  task automatic test_abort_s2();
    logic [1:0] ph [1:5];
    logic [5:1] en_e, ab_e;
    ph   = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
    en_e = 5'b01101;
    ab_e = 5'b01000;
    dwell_s1 = 8'd2; dwell_s2 = 8'd3; rep = 4'd1;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      start = 1'b0;
      abort = (c == 3);
      total++;
      if (phase !== ph[c] || en !== en_e[c] || aborted !== ab_e[c] || done !== 1'b0) begin
        bad++;
        $display("FAIL abort_s2 c%0d: got ph=%b en=%b ab=%b dn=%b want ph=%b en=%b ab=%b dn=0",
                 c, phase, en, aborted, done, ph[c], en_e[c], ab_e[c]);
      end
    end
  endtask

  task automatic test_abort_wrap();
    logic [1:0] ph [1:6];
    logic [6:1] en_e, ab_e, bz_e;
    ph   = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    en_e = 6'b000111;
    ab_e = 6'b001000;
    bz_e = 6'b000111;
    dwell_s1 = 8'd1; dwell_s2 = 8'd1; rep = 4'd1;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      start = 1'b0;
      abort = (c == 3);
      total++;
      if (phase !== ph[c] || en !== en_e[c] || aborted !== ab_e[c] || busy !== bz_e[c] ||
          done !== 1'b0) begin
        bad++;
        $display("FAIL abort_wrap c%0d: got ph=%b en=%b ab=%b bz=%b dn=%b want ph=%b en=%b ab=%b bz=%b dn=0",
                 c, phase, en, aborted, busy, done, ph[c], en_e[c], ab_e[c], bz_e[c]);
      end
    end
  endtask

  task automatic test_idle_abort();
    // Abort alone in IDLE is ignored; start+abort together starts a clean run.
    abort = 1'b1;
    cyc();
    cyc();
    total++;
    if (busy !== 1'b0 || aborted !== 1'b0 || en !== 1'b0) begin
      bad++;
      $display("FAIL idle_abort: got bz=%b ab=%b en=%b want 0 0 0", busy, aborted, en);
    end
    dwell_s1 = 8'd1; dwell_s2 = 8'd1; rep = 4'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (phase !== 2'b01 || en !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start_abort_start: got ph=%b en=%b bz=%b want 01 1 1", phase, en, busy);
    end
    cyc();
    cyc();
    total++;
    if (done !== 1'b1 || aborted !== 1'b0 || phase !== 2'b00) begin
      bad++;
      $display("FAIL start_abort_done: got dn=%b ab=%b ph=%b want 1 0 00", done, aborted, phase);
    end
  endtask

  task automatic test_back_to_back();
    dwell_s1 = 8'd1; dwell_s2 = 8'd1; rep = 4'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    dwell_s1 = 8'd2;
    start = 1'b1;
    cyc();  // cycle 3: done, new start sampled at next edge
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_done: got dn=%b bz=%b want 1 0", done, busy);
    end
    cyc();
    start = 1'b0;
    total++;
    if (phase !== 2'b01 || en !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart: got ph=%b en=%b want 01 1", phase, en);
    end
    cyc();
    total++;
    if (phase !== 2'b01 || en !== 1'b0) begin
      bad++;
      $display("FAIL b2b_new_dwell: got ph=%b en=%b want 01 0", phase, en);
    end
    cyc();
    cyc();
    cyc();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || phase !== 2'b00) begin
      bad++;
      $display("FAIL b2b_end: got dn=%b bz=%b ph=%b want 0 0 00", done, busy, phase);
    end
  endtask

  task automatic test_restart_reset();
    dwell_s1 = 8'd3; dwell_s2 = 8'd4; rep = 4'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1;  // re-pulse mid-run
    cyc();
    start = 1'b0;
    total++;
    if (phase !== 2'b01 || en !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_ignored: got ph=%b en=%b bz=%b want 01 0 1", phase, en, busy);
    end
    cyc();
    total++;
    if (phase !== 2'b10 || en !== 1'b1) begin
      bad++;
      $display("FAIL restart_s2_timing: got ph=%b en=%b want 10 1", phase, en);
    end
    cyc();
    rst_n = 1'b0;
    #1;
    total++;
    if ({en, phase, busy, done, aborted} !== 6'b0) begin
      bad++;
      $display("FAIL midrun_reset: got %b want 000000", {en, phase, busy, done, aborted});
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      total++;
      if (phase !== 2'b00 || busy !== 1'b0 || en !== 1'b0) begin
        bad++;
        $display("FAIL no_resume c%0d: got ph=%b bz=%b en=%b want 00 0 0", c, phase, busy, en);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    mon_on = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    dwell_s1 = '0;
    dwell_s2 = '0;
    rep = '0;
    test_reset();
    mon_on = 1'b1;
    test_basic();
    cyc();
    test_rep();
    cyc();
    test_zero_dwell();
    cyc();
    test_abort_s1();
    cyc();
    test_abort_s2();
    cyc();
    test_abort_wrap();
    cyc();
    test_idle_abort();
    cyc();
    test_back_to_back();
    cyc();
    test_restart_reset();
    cyc();
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
